// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and BCD limits for the stopwatch
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LAP  = 2'd2,
      ST_STOP = 2'd3
   } sw_state_e;

   localparam logic [3:0] BCD_MAX_NINE    = 4'd9;
   localparam logic [3:0] BCD_MAX_FIVE    = 4'd5;
   localparam int         MAX_MIN_DEFAULT = 59;

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one mod-(LIMIT+1) BCD digit with ripple carry
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter logic [3:0] LIMIT = BCD_MAX_NINE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc_in,
   input  logic       clear,
   output logic [3:0] digit,
   output logic       carry_out
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   // clear wins over increment so a wrap can zero the whole chain in one edge
   always_comb begin
      digit_d = digit_q;
      if (clear) begin
         digit_d = 4'd0;
      end else if (inc_in) begin
         digit_d = (digit_q == LIMIT) ? 4'd0 : digit_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit     = digit_q;
   assign carry_out = inc_in & (digit_q == LIMIT);

endmodule

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - mm:ss.cc stopwatch with start/stop, lap freeze and clear
module stopwatch_controller
   import stopwatch_pkg::*;
#(
   parameter int MAX_MIN = MAX_MIN_DEFAULT
) (
   input  logic       clk_50mhz,
   input  logic       rst,
   input  logic       clk_100hz,
   input  logic       btn_ss,
   input  logic       btn_lap,
   output logic [3:0] cs_tens,
   output logic [3:0] cs_ones,
   output logic [3:0] s_tens,
   output logic [3:0] s_ones,
   output logic [3:0] m_tens,
   output logic [3:0] m_ones,
   output logic       running,
   output logic       lap_hold,
   output logic       wrap
);

   localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MIN / 10);
   localparam logic [3:0] MIN_ONES_MAX = 4'(MAX_MIN % 10);

   sw_state_e   state_q, state_d;
   logic        clk_prev_q, clk_prev_d;
   logic        ss_prev_q, ss_prev_d;
   logic        lap_prev_q, lap_prev_d;
   logic [23:0] disp_q, disp_d;
   logic        wrap_q, wrap_d;

   logic        tick, ss_press, lap_press, count_inc;
   logic        at_max_min, wrap_event, cnt_clear;
   logic [3:0]  cnt_cs1, cnt_cs10, cnt_s1, cnt_s10, cnt_m1, cnt_m10;
   logic        c_cs1, c_cs10, c_s1, c_s10, c_m1, c_m10;
   logic [23:0] cnt_all;

   assign tick      = clk_100hz & ~clk_prev_q;
   assign ss_press  = btn_ss & ~ss_prev_q;
   // start/stop has priority; a simultaneous lap press is dropped
   assign lap_press = btn_lap & ~lap_prev_q & ~ss_press;
   assign count_inc = tick & ((state_q == ST_RUN) || (state_q == ST_LAP));

   assign at_max_min = (cnt_m10 == MIN_TENS_MAX) && (cnt_m1 == MIN_ONES_MAX);
   assign wrap_event = c_m10 | (c_s10 & at_max_min);
   assign cnt_clear  = (state_q == ST_IDLE) | wrap_event;
   assign cnt_all    = {cnt_m10, cnt_m1, cnt_s10, cnt_s1, cnt_cs10, cnt_cs1};

   bcd_digit_counter #(.LIMIT(BCD_MAX_NINE)) u_cs_ones (
      .clk(clk_50mhz), .rst(rst), .inc_in(count_inc), .clear(cnt_clear),
      .digit(cnt_cs1), .carry_out(c_cs1));
   bcd_digit_counter #(.LIMIT(BCD_MAX_NINE)) u_cs_tens (
      .clk(clk_50mhz), .rst(rst), .inc_in(c_cs1), .clear(cnt_clear),
      .digit(cnt_cs10), .carry_out(c_cs10));
   bcd_digit_counter #(.LIMIT(BCD_MAX_NINE)) u_s_ones (
      .clk(clk_50mhz), .rst(rst), .inc_in(c_cs10), .clear(cnt_clear),
      .digit(cnt_s1), .carry_out(c_s1));
   bcd_digit_counter #(.LIMIT(BCD_MAX_FIVE)) u_s_tens (
      .clk(clk_50mhz), .rst(rst), .inc_in(c_s1), .clear(cnt_clear),
      .digit(cnt_s10), .carry_out(c_s10));
   bcd_digit_counter #(.LIMIT(BCD_MAX_NINE)) u_m_ones (
      .clk(clk_50mhz), .rst(rst), .inc_in(c_s10), .clear(cnt_clear),
      .digit(cnt_m1), .carry_out(c_m1));
   bcd_digit_counter #(.LIMIT(BCD_MAX_FIVE)) u_m_tens (
      .clk(clk_50mhz), .rst(rst), .inc_in(c_m1), .clear(cnt_clear),
      .digit(cnt_m10), .carry_out(c_m10));

   always_comb begin
      state_d    = state_q;
      clk_prev_d = clk_100hz;
      ss_prev_d  = btn_ss;
      lap_prev_d = btn_lap;
      wrap_d     = wrap_event;
      disp_d     = (state_q == ST_LAP) ? disp_q : cnt_all;
      case (state_q)
         ST_IDLE: if (ss_press) state_d = ST_RUN;
         ST_RUN: begin
            if (ss_press)       state_d = ST_STOP;
            else if (lap_press) state_d = ST_LAP;
         end
         ST_LAP: begin
            if (ss_press)       state_d = ST_STOP;
            else if (lap_press) state_d = ST_RUN;
         end
         ST_STOP: begin
            if (ss_press)       state_d = ST_RUN;
            else if (lap_press) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50mhz) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         clk_prev_q <= 1'b0;
         ss_prev_q  <= 1'b1;
         lap_prev_q <= 1'b1;
         disp_q     <= 24'd0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_prev_q <= clk_prev_d;
         ss_prev_q  <= ss_prev_d;
         lap_prev_q <= lap_prev_d;
         disp_q     <= disp_d;
         wrap_q     <= wrap_d;
      end
   end

   assign {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones} = disp_q;
   assign running  = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign lap_hold = (state_q == ST_LAP);
   assign wrap     = wrap_q;

endmodule
